// File: rtl/bmp_pkg.sv
// Shared FSM state type, header constants and row geometry
// helpers for the BMP stream writer.
package bmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PIXEL,
    PAD,
    DONE
  } bmp_state_e;

  localparam int unsigned HDR_LEN   = 54;
  localparam int unsigned INFO_SIZE = 40;
  localparam int unsigned BIT_COUNT = 24;

  // BMP rows are padded up to a 4-byte boundary.
  function automatic logic [31:0] row_bytes(input int unsigned width);
    return 32'(((3 * width + 3) / 4) * 4);
  endfunction

  function automatic logic [31:0] pad_bytes(input int unsigned width);
    return row_bytes(width) - 32'(3 * width);
  endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Combinational lookup of the 54-byte BMP file + info header.
// All fields are little-endian.
module bmp_header_rom
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512
) (
  input  logic [5:0] idx,
  output logic [7:0] data
);

  localparam logic [31:0] IMG   = row_bytes(WIDTH) * 32'(HEIGHT);
  localparam logic [31:0] FSIZE = 32'(HDR_LEN) + IMG;
  localparam logic [31:0] NEG_H = -32'(HEIGHT);
  localparam logic [31:0] W32   = 32'(WIDTH);
  localparam logic [31:0] OFF   = 32'(HDR_LEN);
  localparam logic [31:0] ISZ   = 32'(INFO_SIZE);

  function automatic logic [7:0] le(
    input logic [31:0] v,
    input logic [1:0]  k
  );
    return v[{k, 3'b000} +: 8];
  endfunction

  // Every 32-bit field starts at an index of 2 mod 4,
  // so the byte lane is idx[1:0] offset by two.
  logic [1:0] k;
  assign k = idx[1:0] + 2'd2;

  always_comb begin
    data = 8'h00;
    unique case (1'b1)
      idx == 6'd0:                  data = 8'h42;
      idx == 6'd1:                  data = 8'h4D;
      idx inside {[6'd2:6'd5]}:     data = le(FSIZE, k);
      idx inside {[6'd10:6'd13]}:   data = le(OFF, k);
      idx inside {[6'd14:6'd17]}:   data = le(ISZ, k);
      idx inside {[6'd18:6'd21]}:   data = le(W32, k);
      idx inside {[6'd22:6'd25]}:   data = le(NEG_H, k);
      idx == 6'd26:                 data = 8'h01;
      idx == 6'd28:                 data = 8'(BIT_COUNT);
      idx inside {[6'd34:6'd37]}:   data = le(IMG, k);
      default:                      data = 8'h00;
    endcase
  end

endmodule

// File: rtl/bmp_stream_writer.sv
// Serialises a pixel beat stream into a top-down 24-bit BMP
// byte stream: header, B/G/R pixel bytes, row padding.
module bmp_stream_writer
  import bmp_pkg::*;
#(
  parameter int WIDTH        = 512,
  parameter int HEIGHT       = 512,
  parameter int PIX_PER_BEAT = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [24*PIX_PER_BEAT-1:0] in_data,
  input  logic                      in_sof,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_byte,
  output logic                      out_last,
  output logic                      frame_done,
  output logic                      sof_err
);

  localparam int BEATS = WIDTH / PIX_PER_BEAT;
  localparam int BPB   = 3 * PIX_PER_BEAT;
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int RW    = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam int NPAD  = int'(pad_bytes(WIDTH));

  localparam logic [CW-1:0] COL_LAST  = CW'(BEATS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [3:0]    BYTE_LAST = 4'(BPB - 1);
  localparam logic [1:0]    PAD_LAST  = NPAD > 0 ? 2'(NPAD - 1) : 2'd0;
  localparam logic [5:0]    HDR_LAST  = 6'(HDR_LEN - 1);

  bmp_state_e state;

  logic [5:0]    hidx;
  logic [3:0]    bidx;
  logic [1:0]    pidx;
  logic [CW-1:0] out_col, in_col;
  logic [RW-1:0] out_row, in_row;
  logic          acc_done;
  logic          hold_full;
  logic [24*PIX_PER_BEAT-1:0] hold_data;
  logic [7:0]    hdr_byte;

  logic out_fire, in_fire, beat_end, row_end;
  logic last_row, first_beat, take;

  bmp_header_rom #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_rom (
    .idx  (hidx),
    .data (hdr_byte)
  );

  assign out_fire   = out_valid && out_ready;
  assign in_fire    = in_valid && in_ready;
  assign beat_end   = state == PIXEL && hold_full && bidx == BYTE_LAST;
  assign row_end    = beat_end && out_col == COL_LAST;
  assign last_row   = out_row == ROW_LAST;
  assign first_beat = in_col == '0 && in_row == '0;
  assign frame_done = state == DONE;

  // Refill the holding register while its last byte leaves,
  // so beats flow without bubbles across rows and pads.
  assign take = !acc_done && (!hold_full || (beat_end && out_ready));

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    unique case (state)
      IDLE: in_ready = in_valid && !in_sof;
      HEADER: begin
        in_ready  = take;
        out_valid = 1'b1;
        out_byte  = hdr_byte;
      end
      PIXEL: begin
        in_ready  = take;
        out_valid = hold_full;
        out_byte  = hold_data[{bidx, 3'b000} +: 8];
        out_last  = row_end && last_row && NPAD == 0;
      end
      PAD: begin
        in_ready  = take;
        out_valid = 1'b1;
        out_last  = pidx == PAD_LAST && last_row;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      hidx      <= '0;
      bidx      <= '0;
      pidx      <= '0;
      out_col   <= '0;
      out_row   <= '0;
      in_col    <= '0;
      in_row    <= '0;
      acc_done  <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= '0;
      sof_err   <= 1'b0;
    end else begin
      sof_err <= in_fire && (state == IDLE || (in_sof && !first_beat));

      if (in_fire && state != IDLE) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
        if (in_col == COL_LAST) begin
          in_col <= '0;
          if (in_row == ROW_LAST) acc_done <= 1'b1;
          else in_row <= in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end else if (beat_end && out_ready) begin
        hold_full <= 1'b0;
      end

      unique case (state)
        IDLE: if (in_valid && in_sof) state <= HEADER;
        HEADER: if (out_fire) begin
          if (hidx == HDR_LAST) begin
            hidx  <= '0;
            state <= PIXEL;
          end else begin
            hidx <= hidx + 1'b1;
          end
        end
        PIXEL: if (out_fire) begin
          if (bidx == BYTE_LAST) begin
            bidx <= '0;
            if (out_col == COL_LAST) begin
              out_col <= '0;
              if (NPAD > 0) state <= PAD;
              else if (last_row) state <= DONE;
              else out_row <= out_row + 1'b1;
            end else begin
              out_col <= out_col + 1'b1;
            end
          end else begin
            bidx <= bidx + 1'b1;
          end
        end
        PAD: if (out_fire) begin
          if (pidx == PAD_LAST) begin
            pidx <= '0;
            if (last_row) begin
              state <= DONE;
            end else begin
              out_row <= out_row + 1'b1;
              state   <= PIXEL;
            end
          end else begin
            pidx <= pidx + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          out_row  <= '0;
          in_col   <= '0;
          in_row   <= '0;
          acc_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Directed bench: a 4x2 two-pixel-beat writer for header, flow,
// framing and reset, and a 5x1 one-pixel writer for row padding.
module tb_bmp_stream_writer;

  logic HCLK;
  logic HRESET;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        a_in_valid, a_in_ready, a_in_sof;
  logic [47:0] a_in_data;
  logic        a_out_valid, a_out_ready, a_out_last;
  logic [7:0]  a_out_byte;
  logic        a_frame_done, a_sof_err;

  logic        b_in_valid, b_in_ready, b_in_sof;
  logic [23:0] b_in_data;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_out_byte;
  logic        b_frame_done, b_sof_err;

  bmp_stream_writer #(
    .WIDTH        (4),
    .HEIGHT       (2),
    .PIX_PER_BEAT (2)
  ) dut_a (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_data    (a_in_data),
    .in_sof     (a_in_sof),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_byte   (a_out_byte),
    .out_last   (a_out_last),
    .frame_done (a_frame_done),
    .sof_err    (a_sof_err)
  );

  bmp_stream_writer #(
    .WIDTH        (5),
    .HEIGHT       (1),
    .PIX_PER_BEAT (1)
  ) dut_b (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_data    (b_in_data),
    .in_sof     (b_in_sof),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_byte   (b_out_byte),
    .out_last   (b_out_last),
    .frame_done (b_frame_done),
    .sof_err    (b_sof_err)
  );

  int checks;
  int errors;

  logic [7:0] exp_a [78];
  logic [7:0] got   [128];
  int nbytes, last_idx, last_cnt, done_cnt, serr_cnt, gap_cnt, unstable_cnt;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check(tag, 32'({a_in_ready, a_out_valid, a_out_byte,
                    a_out_last, a_frame_done, a_sof_err}), 32'h0);
  endtask

  function automatic logic [47:0] beat_a(input int j);
    logic [23:0] p0, p1;
    p0 = 24'hA0B0C0 + 24'(2 * j) * 24'h010101;
    p1 = 24'hA0B0C0 + 24'(2 * j + 1) * 24'h010101;
    return {p1, p0};
  endfunction

  function automatic int mism_a();
    int m;
    m = 0;
    for (int i = 0; i < 78; i++) if (got[i] !== exp_a[i]) m++;
    return m;
  endfunction

  // One frame on dut_a; optional random stalls, an extra sof on
  // beat sof_at, or a reset once rst_at bytes have been taken.
  task automatic run_a(input bit stall, input int sof_at, input int rst_at);
    int beat, tail;
    bit started, prev_stall;
    logic [7:0] prev_byte;
    logic prev_last;
    beat = 0; tail = 0; started = 0; prev_stall = 0;
    prev_byte = 8'h00; prev_last = 1'b0;
    nbytes = 0; last_idx = -1; last_cnt = 0; done_cnt = 0;
    serr_cnt = 0; gap_cnt = 0; unstable_cnt = 0;
    for (int cyc = 0; cyc < 600 && tail < 3; cyc++) begin
      a_in_valid  = beat < 4;
      a_in_data   = beat_a(beat);
      a_in_sof    = beat == 0 || beat == sof_at;
      a_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_at >= 0 && nbytes == rst_at) begin
        HRESET = 1'b1;
        a_in_valid = 1'b0;
        a_in_sof = 1'b0;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        check_idle_a("reset_mid_frame");
        return;
      end
      @(negedge HCLK);
      if (prev_stall && a_out_valid &&
          (a_out_byte !== prev_byte || a_out_last !== prev_last))
        unstable_cnt++;
      prev_stall = a_out_valid && !a_out_ready;
      prev_byte  = a_out_byte;
      prev_last  = a_out_last;
      if (started && !a_out_valid && last_idx < 0) gap_cnt++;
      if (a_out_valid) started = 1;
      if (a_frame_done) done_cnt++;
      if (a_sof_err) serr_cnt++;
      if (a_out_valid && a_out_ready && nbytes < 128) begin
        got[nbytes] = a_out_byte;
        if (a_out_last) begin
          last_idx = nbytes;
          last_cnt++;
        end
        nbytes++;
      end
      if (a_in_valid && a_in_ready) beat++;
      if (done_cnt > 0) tail++;
      @(posedge HCLK); #1;
    end
  endtask

  initial begin
    int bbeat, m;
    checks = 0;
    errors = 0;

    foreach (exp_a[i]) exp_a[i] = 8'h00;
    exp_a[0]  = 8'h42; exp_a[1]  = 8'h4D; exp_a[2]  = 8'h4E;
    exp_a[10] = 8'h36; exp_a[14] = 8'h28; exp_a[18] = 8'h04;
    exp_a[22] = 8'hFE; exp_a[23] = 8'hFF; exp_a[24] = 8'hFF;
    exp_a[25] = 8'hFF; exp_a[26] = 8'h01; exp_a[28] = 8'h18;
    exp_a[34] = 8'h18;
    for (int p = 0; p < 8; p++) begin
      exp_a[54 + 3 * p] = 8'hC0 + 8'(p);
      exp_a[55 + 3 * p] = 8'hB0 + 8'(p);
      exp_a[56 + 3 * p] = 8'hA0 + 8'(p);
    end

    HRESET = 1'b1;
    a_in_valid = 0; a_in_sof = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_sof = 0; b_in_data = '0; b_out_ready = 0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    check_idle_a("reset_a");
    check("reset_b", 32'({b_in_ready, b_out_valid, b_out_byte,
                          b_out_last, b_frame_done, b_sof_err}), 32'h0);

    run_a(1'b0, -1, -1);
    check("tp_nbytes", nbytes, 78);
    check("tp_data", mism_a(), 0);
    check("hdr_fsize", {got[5], got[4], got[3], got[2]}, 32'h0000004E);
    check("hdr_negh", {got[25], got[24], got[23], got[22]}, 32'hFFFFFFFE);
    check("tp_last_idx", last_idx, 77);
    check("tp_last_cnt", last_cnt, 1);
    check("tp_gaps", gap_cnt, 0);
    check("tp_done", done_cnt, 1);
    check("tp_sof_err", serr_cnt, 0);

    a_in_valid = 1'b1; a_in_sof = 1'b0; a_in_data = 48'h123456789ABC;
    @(negedge HCLK);
    check("idle_drop_ready", a_in_ready, 1'b1);
    @(posedge HCLK); #1;
    a_in_valid = 1'b0;
    check("idle_sof_err", a_sof_err, 1'b1);
    check("idle_no_out", a_out_valid, 1'b0);
    @(posedge HCLK); #1;
    check("idle_sof_err_pulse", a_sof_err, 1'b0);
    a_in_valid = 1'b1; a_in_sof = 1'b1; a_in_data = beat_a(0);
    @(negedge HCLK);
    check("idle_sof_hold", a_in_ready, 1'b0);
    @(posedge HCLK); #1;

    run_a(1'b0, -1, -1);
    check("after_drop_data", mism_a(), 0);

    run_a(1'b0, 2, -1);
    check("midsof_data", mism_a(), 0);
    check("midsof_err", serr_cnt, 1);
    check("midsof_done", done_cnt, 1);

    run_a(1'b1, -1, -1);
    check("bp_nbytes", nbytes, 78);
    check("bp_data", mism_a(), 0);
    check("bp_stable", unstable_cnt, 0);
    check("bp_last_idx", last_idx, 77);
    check("bp_done", done_cnt, 1);

    run_a(1'b0, -1, 60);
    run_a(1'b0, -1, -1);
    check("rst_first", got[0], 8'h42);
    check("rst_nbytes", nbytes, 78);
    check("rst_data", mism_a(), 0);

    nbytes = 0; bbeat = 0; done_cnt = 0; last_idx = -1;
    for (int cyc = 0; cyc < 300 && done_cnt == 0; cyc++) begin
      b_in_valid  = bbeat < 5;
      b_in_sof    = bbeat == 0;
      b_in_data   = 24'h112233;
      b_out_ready = 1'b1;
      @(negedge HCLK);
      if (b_frame_done) done_cnt++;
      if (b_out_valid && b_out_ready && nbytes < 128) begin
        got[nbytes] = b_out_byte;
        if (b_out_last) last_idx = nbytes;
        nbytes++;
      end
      if (b_in_valid && b_in_ready) bbeat++;
      @(posedge HCLK); #1;
    end
    m = 0;
    for (int i = 0; i < 5; i++) begin
      if (got[54 + 3 * i] !== 8'h33) m++;
      if (got[55 + 3 * i] !== 8'h22) m++;
      if (got[56 + 3 * i] !== 8'h11) m++;
    end
    check("pad_nbytes", nbytes, 70);
    check("pad_fsize", {got[5], got[4], got[3], got[2]}, 32'h00000046);
    check("pad_img", {got[37], got[36], got[35], got[34]}, 32'h00000010);
    check("pad_pixels", m, 0);
    check("pad_byte", got[69], 8'h00);
    check("pad_last_idx", last_idx, 69);
    check("pad_done", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmp_stream_writer.md
BMP_STREAM_WRITER -- requirements
Module: bmp_stream_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 512, image width in pixels; WIDTH must be a multiple of PIX_PER_BEAT.
REQ-002 SHALL have parameter HEIGHT, default 512, image height in rows.
REQ-003 SHALL have parameter PIX_PER_BEAT, default 2, pixels per input beat, legal range 1..4.
REQ-004 SHALL have port HCLK, input, 1, the single clock.
REQ-005 SHALL have port HRESET, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, input beat valid.
REQ-007 SHALL have port in_ready, output, 1, input beat accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_data, input, 24*PIX_PER_BEAT, input pixels; pixel k occupies bits [24k+23:24k] as {R,G,B}; pixel 0 is leftmost.
REQ-009 SHALL have port in_sof, input, 1, marks the first beat of a frame.
REQ-010 SHALL have port out_valid, output, 1, output byte valid.
REQ-011 SHALL have port out_ready, input, 1, sink accepts the byte when out_valid and out_ready are both high.
REQ-012 SHALL have port out_byte, output, 8, serialized BMP file byte.
REQ-013 SHALL have port out_last, output, 1, high with the final byte of the file.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse after the last byte is accepted.
REQ-015 SHALL have port sof_err, output, 1, one-cycle pulse on a framing error.

Function
REQ-016 SHALL implement states IDLE, HEADER, PIXEL, PAD and DONE.
REQ-017 In IDLE, in_ready=0 while in_valid&&in_sof; that beat is not consumed, and the FSM moves to HEADER on the next cycle.
REQ-018 In IDLE, a beat with in_valid&&!in_sof SHALL be accepted (in_ready=1), discarded, and SHALL pulse sof_err on the following cycle.
REQ-019 In HEADER, the block SHALL emit 54 bytes (index 0..53), advancing one byte per accepted transfer, with out_valid=1 starting the first cycle in HEADER.
REQ-020 Header byte fields (all little-endian):
  - 0-1: 0x42 0x4D
  - 2-5: 54+ROWBYTES*HEIGHT
  - 6-9: 0
  - 10-13: 54
  - 14-17: 40
  - 18-21: WIDTH
  - 22-25: -HEIGHT, two's complement, top-down
  - 26-27: 1
  - 28-29: 24
  - 30-33: 0
  - 34-37: ROWBYTES*HEIGHT
  - 38-53: 0
REQ-021 ROWBYTES SHALL equal ceil(3*WIDTH/4)*4; PAD SHALL equal ROWBYTES-3*WIDTH (range 0..3).
REQ-022 In PIXEL, a one-beat holding register SHALL capture accepted beats, and its bytes SHALL be emitted as B,G,R of pixel 0, then pixel 1, and so on (3*PIX_PER_BEAT bytes per beat).
REQ-023 In PIXEL, in_ready SHALL be 1 when the holding register is empty, or when its last byte is being accepted in the same cycle, so that back-to-back beats produce gap-free output.
REQ-024 After the last byte of each row: if PAD>0, go to PAD and emit PAD bytes of 0x00; otherwise begin the next row.
REQ-025 After the last byte of row HEIGHT-1 (including its pad bytes), assert out_last on that byte, then go to DONE.
REQ-026 In DONE, pulse frame_done for one cycle, then return to IDLE.
REQ-027 While out_valid=1 and out_ready=0, out_byte and out_last SHALL be held stable.
REQ-028 A beat accepted in PIXEL with in_sof=1, other than the first beat of the frame, SHALL still be used as pixel data and SHALL pulse sof_err.
REQ-029 Outside HEADER, PIXEL and PAD, out_valid SHALL be 0.
REQ-030 Row and column counters SHALL be $clog2-sized from HEIGHT and WIDTH/PIX_PER_BEAT; header arithmetic SHALL be 32-bit.

Reset
REQ-031 While HRESET=1 at a rising HCLK edge, the block SHALL clear:
  - state to IDLE
  - all counters to 0
  - the holding register to empty
  - in_ready, out_valid, out_byte, out_last, frame_done and sof_err to 0
REQ-032 Reset asserted mid-frame SHALL abandon the frame; the next frame SHALL start again from header byte 0.

Structure
REQ-033 Package bmp_pkg SHALL hold:
  - the state enum
  - the header length (54), info-header size (40) and bit count (24)
  - functions computing ROWBYTES and PAD
REQ-034 Sub-module bmp_header_rom SHALL be combinational, parametrised by WIDTH and HEIGHT, and map a 6-bit index to a header byte.

Verification
REQ-035 Header check: WIDTH=4, HEIGHT=2, PIX_PER_BEAT=2 -> bytes 2-5 = 4E 00 00 00; bytes 22-25 = FE FF FF FF; total 78 bytes, out_last on byte 77.
REQ-036 Padding check: WIDTH=5, HEIGHT=1, PIX_PER_BEAT=1, pixels {R,G,B}=0x112233 -> each pixel emitted as 33 22 11; one 0x00 pad after 15 data bytes; bytes 34-37 = 10 00 00 00.
REQ-037 Backpressure check: out_ready toggles randomly -> out_byte is stable while stalled; the byte sequence equals the no-stall run.
REQ-038 Throughput check: out_ready=1 and in_valid=1 for the whole frame -> out_valid stays high from header byte 0 to the last byte; frame_done pulses exactly once.
REQ-039 Framing check: non-sof beat in IDLE -> dropped, sof_err pulses once; in_sof on the third beat of a frame -> sof_err pulses and the data is still emitted.
REQ-040 Reset check: HRESET asserted at byte 60 -> all outputs are 0 the next cycle; the following frame emits 0x42 first.
